// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, state enum and clamp helper for the 3x3 window fetcher
// Contents:
//   TAPS            number of taps in a 3x3 window
//   TAP_DR / TAP_DC row/column offset of each tap, tap 0 = top-left, tap 8 = bottom-right
//   state_t         fetcher FSM states
//   clamp_idx()     replicate-border clamp of a signed index into [0, max_val]
package conv_pkg;

  localparam int TAPS = 9;

  localparam int TAP_DR [TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DC [TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_PRESENT
  } state_t;

  function automatic int clamp_idx(input int val, input int max_val);
    if (val < 0) return 0;
    if (val > max_val) return max_val;
    return val;
  endfunction

endpackage

// File: rtl/conv_tap_addr_gen.sv
// rtl/conv_tap_addr_gen.sv - combinational clamped BRAM address for one tap of a 3x3 window
// Ports:
//   row, col  centre pixel of the window
//   tap       tap index 0..8 (values above 8 are treated as tap 8)
//   addr      row-major address of the border-clamped tap pixel
module conv_tap_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H),
  parameter int ROW_W  = $clog2(IMG_H),
  parameter int COL_W  = $clog2(IMG_W)
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [3:0]        tap,
  output logic [ADDR_W-1:0] addr
);

  int tap_i;
  int r_cl;
  int c_cl;

  always_comb begin
    tap_i = (int'(tap) > TAPS - 1) ? TAPS - 1 : int'(tap);
    r_cl  = clamp_idx(int'(row) + TAP_DR[tap_i], IMG_H - 1);
    c_cl  = clamp_idx(int'(col) + TAP_DC[tap_i], IMG_W - 1);
    // Computed in 32-bit arithmetic; ADDR_W always covers IMG_W*IMG_H-1.
    addr  = ADDR_W'(r_cl * IMG_W + c_cl);
  end

endmodule

// File: rtl/conv_window_fetch.sv
// rtl/conv_window_fetch.sv - raster-order 3x3 neighbourhood fetcher with valid/ready window output
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, busy, done   frame control: start pulse, busy while walking, done pulse at end
//   mem_en, mem_addr    BRAM read port request
//   mem_dout            BRAM read data, RD_LAT cycles after the address
//   win_data            9 taps, tap0 in the MSBs
//   win_row, win_col    centre coordinates of the presented window
//   win_valid/win_ready window handshake
module conv_window_fetch
  import conv_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [PIX_W-1:0]           mem_dout,
  output logic [TAPS*PIX_W-1:0]      win_data,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       win_valid,
  input  logic                       win_ready
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int DW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [3:0]    LAST_TAP   = 4'(TAPS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT - 1);

  state_t              state, state_nxt;
  logic [3:0]          tap;
  logic [DW-1:0]       drain_cnt;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic [ADDR_W-1:0]   tap_addr;
  logic [ADDR_W-1:0]   addr_hold;
  logic                pipe_vld [RD_LAT];
  logic [3:0]          pipe_tap [RD_LAT];
  logic [PIX_W-1:0]    slot [TAPS];
  logic                done_q;
  logic                last_pix;
  logic                handshake;

  assign last_pix  = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  assign handshake = (state == ST_PRESENT) && win_ready;

  conv_tap_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_addr_gen (
    .row  (row),
    .col  (col),
    .tap  (tap),
    .addr (tap_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_FETCH;
      ST_FETCH:   if (tap == LAST_TAP) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = ST_PRESENT;
      ST_PRESENT: if (win_ready) state_nxt = last_pix ? ST_IDLE : ST_FETCH;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tap       <= '0;
      drain_cnt <= '0;
      row       <= '0;
      col       <= '0;
      addr_hold <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_tap[i] <= '0;
      end
      for (int k = 0; k < TAPS; k++) slot[k] <= '0;
    end else begin
      tap       <= (state == ST_FETCH) ? tap + 4'd1 : 4'd0;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DW'(1) : '0;
      if (state == ST_FETCH) addr_hold <= tap_addr;

      if (state == ST_IDLE && start) begin
        row <= '0;
        col <= '0;
      end else if (handshake && !last_pix) begin
        if (col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      done_q <= handshake && last_pix;

      // Tap index travels alongside the read so data lands in the right slot.
      pipe_vld[0] <= (state == ST_FETCH);
      pipe_tap[0] <= tap;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tap[i] <= pipe_tap[i-1];
      end

      for (int k = 0; k < TAPS; k++) begin
        if (pipe_vld[RD_LAT-1] && pipe_tap[RD_LAT-1] == 4'(k)) slot[k] <= mem_dout;
      end
    end
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    mem_en    = (state == ST_FETCH);
    mem_addr  = mem_en ? tap_addr : addr_hold;
    win_valid = (state == ST_PRESENT);
    done      = done_q;
    win_row   = row;
    win_col   = col;
    win_data  = '0;
    for (int k = 0; k < TAPS; k++) win_data[(TAPS-1-k)*PIX_W +: PIX_W] = slot[k];
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
// tb/tb_conv_window_fetch.sv - self-checking bench for conv_window_fetch on a 4x4 frame
module tb_conv_window_fetch;

  localparam int PIX_W = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int AW    = 4;
  localparam int WW    = 9 * PIX_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, rdy;
  int   sel;
  int   checks = 0;
  int   errors = 0;

  logic [PIX_W-1:0] mem [IMG_W*IMG_H];
  logic [WW-1:0]    got [IMG_W*IMG_H];

  logic start1, busy1, done1, en1, valid1, ready1;
  logic [AW-1:0] addr1;
  logic [PIX_W-1:0] dout1;
  logic [WW-1:0] data1;
  logic [1:0] row1, col1;

  logic start2, busy2, done2, en2, valid2, ready2;
  logic [AW-1:0] addr2;
  logic [PIX_W-1:0] dout2;
  logic [WW-1:0] data2;
  logic [1:0] row2, col2;

  assign start1 = start && (sel == 0);
  assign start2 = start && (sel == 1);
  assign ready1 = rdy && (sel == 0);
  assign ready2 = rdy && (sel == 1);

  conv_window_fetch #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .RD_LAT(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .mem_en(en1), .mem_addr(addr1), .mem_dout(dout1), .win_data(data1),
    .win_row(row1), .win_col(col1), .win_valid(valid1), .win_ready(ready1)
  );

  conv_window_fetch #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .RD_LAT(2), .ADDR_W(AW)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .mem_en(en2), .mem_addr(addr2), .mem_dout(dout2), .win_data(data2),
    .win_row(row2), .win_col(col2), .win_valid(valid2), .win_ready(ready2)
  );

  // BRAM models: one and two register stages of read latency.
  logic [PIX_W-1:0] d1a, d2a, d2b;
  always @(posedge clk) begin
    d1a <= mem[addr1];
    d2a <= mem[addr2];
    d2b <= d2a;
  end
  assign dout1 = d1a;
  assign dout2 = d2b;

  logic          cv, cbusy, cdone, cen;
  logic [WW-1:0] cdata;
  logic [1:0]    crow, ccol;
  assign cv    = (sel == 1) ? valid2 : valid1;
  assign cbusy = (sel == 1) ? busy2  : busy1;
  assign cdone = (sel == 1) ? done2  : done1;
  assign cen   = (sel == 1) ? en2    : en1;
  assign cdata = (sel == 1) ? data2  : data1;
  assign crow  = (sel == 1) ? row2   : row1;
  assign ccol  = (sel == 1) ? col2   : col1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Reference window straight from the neighbourhood definition.
  function automatic logic [WW-1:0] model_win(input int r, input int c);
    logic [WW-1:0] w;
    int rr, cc;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      rr = clampi(r + k / 3 - 1, IMG_H - 1);
      cc = clampi(c + k % 3 - 1, IMG_W - 1);
      w[(8-k)*PIX_W +: PIX_W] = mem[rr*IMG_W + cc];
    end
    return w;
  endfunction

  task automatic fill_identity();
    for (int a = 0; a < IMG_W*IMG_H; a++) mem[a] = 8'(a);
  endtask

  task automatic fill_random();
    for (int a = 0; a < IMG_W*IMG_H; a++) mem[a] = 8'($urandom);
  endtask

  task automatic run_frame(input string name, input bit rand_rdy, input bit hold11, input int exp_lat);
    int cnt, hs, last_hs, done_cnt, extra;
    bit held;
    logic [WW-1:0] snap;
    rdy   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 1;
    while (!cv && cnt < 100) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, cnt, exp_lat);
    end
    hs = 0; last_hs = -10; done_cnt = 0; held = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cdone) begin
        done_cnt++;
        checks++;
        if (cbusy !== 1'b0 || cyc != last_hs + 1) begin
          errors++;
          $display("FAIL %s done_timing: busy=%0b done_cycle=%0d required busy=0 cycle=%0d", name, cbusy, cyc, last_hs + 1);
        end
        break;
      end
      if (hold11 && !held && cv && crow == 2'd1 && ccol == 2'd1) begin
        held = 1'b1;
        snap = cdata;
        rdy  = 1'b0;
        for (int i = 0; i < 5; i++) begin
          tick();
          cyc++;
          checks++;
          if (cdata !== snap || crow !== 2'd1 || ccol !== 2'd1 || cen !== 1'b0 || cv !== 1'b1) begin
            errors++;
            $display("FAIL %s stall_hold: data=%h row=%0d col=%0d en=%0b valid=%0b required data=%h row=1 col=1 en=0 valid=1",
                     name, cdata, crow, ccol, cen, cv, snap);
          end
        end
      end
      rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (cv && rdy) begin
        checks++;
        if (crow !== 2'(hs / IMG_W) || ccol !== 2'(hs % IMG_W)) begin
          errors++;
          $display("FAIL %s order: got (%0d,%0d) required (%0d,%0d)", name, crow, ccol, hs / IMG_W, hs % IMG_W);
        end
        checks++;
        if (cdata !== model_win(hs / IMG_W, hs % IMG_W)) begin
          errors++;
          $display("FAIL %s window(%0d,%0d): got %h required %h", name, hs / IMG_W, hs % IMG_W, cdata,
                   model_win(hs / IMG_W, hs % IMG_W));
        end
        if (hs < IMG_W*IMG_H) got[hs] = cdata;
        hs++;
        last_hs = cyc;
      end
      tick();
    end
    rdy = 1'b0;
    checks++;
    if (done_cnt != 1 || hs != IMG_W*IMG_H) begin
      errors++;
      $display("FAIL %s frame_count: handshakes=%0d done=%0d required 16 and 1", name, hs, done_cnt);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cdone || cbusy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL %s after_done: got %0d cycles with done/busy required 0", name, extra);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || en1 !== 1'b0 || addr1 !== '0) begin
      errors++;
      $display("FAIL %s ctrl: busy=%0b done=%0b en=%0b addr=%0d required all 0", name, busy1, done1, en1, addr1);
    end
    checks++;
    if (valid1 !== 1'b0 || data1 !== '0 || row1 !== 2'd0 || col1 !== 2'd0) begin
      errors++;
      $display("FAIL %s window: valid=%0b data=%h row=%0d col=%0d required all 0", name, valid1, data1, row1, col1);
    end
  endtask

  task automatic test_reset();
    sel = 0; start = 1'b0; rdy = 1'b0; reset = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    checks++;
    if (busy2 !== 1'b0 || valid2 !== 1'b0 || data2 !== '0) begin
      errors++;
      $display("FAIL reset dut2: busy=%0b valid=%0b data=%h required 0", busy2, valid2, data2);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_identity_frame();
    sel = 0;
    fill_identity();
    run_frame("ident", 1'b0, 1'b0, 11);
    checks++;
    if (got[0] !== {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd4, 8'd4, 8'd5}) begin
      errors++; $display("FAIL ident_w00: got %h", got[0]);
    end
    checks++;
    if (got[7] !== {8'd2, 8'd3, 8'd3, 8'd6, 8'd7, 8'd7, 8'd10, 8'd11, 8'd11}) begin
      errors++; $display("FAIL ident_w13: got %h", got[7]);
    end
    checks++;
    if (got[15] !== {8'd10, 8'd11, 8'd11, 8'd14, 8'd15, 8'd15, 8'd14, 8'd15, 8'd15}) begin
      errors++; $display("FAIL ident_w33: got %h", got[15]);
    end
    checks++;
    if (got[5] !== {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}) begin
      errors++; $display("FAIL ident_w11: got %h", got[5]);
    end
  endtask

  task automatic test_stall();
    sel = 0;
    fill_identity();
    run_frame("stall_ident", 1'b0, 1'b1, 11);
    fill_random();
    run_frame("stall_rand", 1'b1, 1'b1, 11);
  endtask

  task automatic test_rdlat2();
    sel = 1;
    fill_identity();
    run_frame("lat2_ident", 1'b0, 1'b0, 12);
    checks++;
    if (got[0] !== {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd4, 8'd4, 8'd5}) begin
      errors++; $display("FAIL lat2_w00: got %h", got[0]);
    end
    checks++;
    if (got[15] !== {8'd10, 8'd11, 8'd11, 8'd14, 8'd15, 8'd15, 8'd14, 8'd15, 8'd15}) begin
      errors++; $display("FAIL lat2_w33: got %h", got[15]);
    end
    fill_random();
    run_frame("lat2_rand", 1'b1, 1'b1, 12);
    sel = 0;
  endtask

  task automatic test_reset_mid();
    int hs, guard, bad;
    sel = 0;
    fill_random();
    rdy = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    hs = 0;
    guard = 0;
    while (!(cv && crow == 2'd2 && ccol == 2'd1) && guard < 1000) begin
      rdy = 1'b1;
      if (cv) begin
        checks++;
        if (crow !== 2'(hs / IMG_W) || ccol !== 2'(hs % IMG_W) || cdata !== model_win(hs / IMG_W, hs % IMG_W)) begin
          errors++;
          $display("FAIL midreset order: got (%0d,%0d) required (%0d,%0d)", crow, ccol, hs / IMG_W, hs % IMG_W);
        end
        hs++;
      end
      tick();
      guard++;
    end
    rdy = 1'b0;
    checks++;
    if (hs != 9) begin
      errors++;
      $display("FAIL midreset reach21: handshakes before (2,1)=%0d required 9", hs);
    end
    reset = 1'b1;
    tick();
    check_zero("midreset");
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done1 || busy1 || valid1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset quiet: got %0d active cycles required 0", bad);
    end
    run_frame("restart", 1'b1, 1'b0, 11);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rdy   = 1'b0;
    sel   = 0;
    test_reset();
    test_identity_frame();
    test_stall();
    test_rdlat2();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
